// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer sample buffer: register map,
// CTRL/STATUS bit positions and capture FSM states.
package la_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_DIV    = 5'h08;
  localparam logic [4:0] OFF_DATA0  = 5'h10;
  localparam logic [4:0] OFF_DATA1  = 5'h14;
  localparam logic [4:0] OFF_DATA2  = 5'h18;
  localparam logic [4:0] OFF_DATA3  = 5'h1C;

  localparam int unsigned CTRL_ARM  = 0;
  localparam int unsigned CTRL_CONT = 1;
  localparam int unsigned CTRL_CLR  = 2;

  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_ACTIVE    = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_COUNT_W   = 7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SAMPLE = 1'b1
  } la_state_e;

endpackage

// File: rtl/la_sample_fifo.sv
// Sample FIFO: power-of-two depth, wrapping pointers, occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module la_sample_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear has priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/la_sample_buffer.sv
// Logic-analyzer sample buffer: Wishbone register window, divided sample
// clock, one-shot/continuous capture FSM feeding a 128-bit sample FIFO.
module la_sample_buffer
  import la_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  input  logic [127:0] la_data_in
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  la_state_e      state, state_next;
  logic           arm, arm_next, cont, clr_bit, ovf;
  logic [15:0]    div, div_cnt;
  logic           req, access, wr, rd;
  logic [4:0]     offset;
  logic           ctrl_wr, clr_now, tick, push, pop, dropped, fills;
  logic [127:0]   dout;
  logic           full, empty;
  logic [CW-1:0]  count;
  logic [31:0]    rdata;
  logic           unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_dat_i[7:3]};

  assign req     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign access  = req && !wbs_ack_o;
  assign wr      = access && wbs_we_i;
  assign rd      = access && !wbs_we_i;
  assign offset  = wbs_adr_i[4:0];
  assign ctrl_wr = wr && (offset == OFF_CTRL) && wbs_sel_i[0];
  assign clr_now = ctrl_wr && wbs_dat_i[CTRL_CLR];

  assign tick    = (state == ST_SAMPLE) && (div_cnt == '0);
  assign pop     = rd && (offset == OFF_DATA3) && !empty && !clr_now;
  assign push    = tick && !clr_now;
  assign dropped = push && full && !pop;
  // The push leaves the FIFO full (a push+pop at FULL stays full).
  assign fills   = push && (full || ((count == CW'(DEPTH - 1)) && !pop));

  la_sample_fifo #(
    .WIDTH(128),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .clr  (clr_now),
    .push (push),
    .pop  (pop),
    .din  (la_data_in),
    .dout (dout),
    .full (full),
    .empty(empty),
    .count(count)
  );

  // Capture FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state and ARM update: bus ARM writes, one-shot completion, CLR last so it wins.
  always_comb begin
    state_next = state;
    arm_next   = arm;
    if (ctrl_wr) arm_next = wbs_dat_i[CTRL_ARM];
    unique case (state)
      ST_IDLE: begin
        if (ctrl_wr && wbs_dat_i[CTRL_ARM]) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (ctrl_wr && !wbs_dat_i[CTRL_ARM]) begin
          state_next = ST_IDLE;
        end else if (fills && !cont) begin
          state_next = ST_IDLE;
          arm_next   = 1'b0;
        end
      end
    endcase
    if (clr_now) begin
      state_next = ST_IDLE;
      arm_next   = 1'b0;
    end
  end

  // Control registers, divider counter and sticky overflow.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      arm     <= 1'b0;
      cont    <= 1'b0;
      clr_bit <= 1'b0;
      ovf     <= 1'b0;
      div     <= '0;
      div_cnt <= '0;
    end else begin
      arm     <= arm_next;
      clr_bit <= clr_now;
      if (ctrl_wr) cont <= wbs_dat_i[CTRL_CONT];
      if (wr && (offset == OFF_DIV)) begin
        if (wbs_sel_i[0]) div[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) div[15:8] <= wbs_dat_i[15:8];
      end
      if (clr_now)              ovf <= 1'b0;
      else if (dropped && cont) ovf <= 1'b1;
      if (state == ST_IDLE) div_cnt <= '0;
      else if (tick)        div_cnt <= div;
      else                  div_cnt <= div_cnt - 1'b1;
    end
  end

  // Register read mux; DATAn read as zero while the FIFO is empty.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL: begin
        rdata[CTRL_ARM]  = arm;
        rdata[CTRL_CONT] = cont;
        rdata[CTRL_CLR]  = clr_bit;
      end
      OFF_STATUS: begin
        rdata[STAT_EMPTY]  = empty;
        rdata[STAT_FULL]   = full;
        rdata[STAT_ACTIVE] = (state == ST_SAMPLE);
        rdata[STAT_OVF]    = ovf;
        rdata[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
      end
      OFF_DIV:   rdata[15:0] = div;
      OFF_DATA0: rdata = empty ? '0 : dout[31:0];
      OFF_DATA1: rdata = empty ? '0 : dout[63:32];
      OFF_DATA2: rdata = empty ? '0 : dout[95:64];
      OFF_DATA3: rdata = empty ? '0 : dout[127:96];
      default:   rdata = '0;
    endcase
  end

  // Registered single-cycle ack with read data captured alongside.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= rd ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_la_sample_buffer.sv
// Randomized self-checking bench for la_sample_buffer. Expected FIFO contents
// come from a log of the driven la_data_in values and the sampling schedule
// (sample k of a capture armed at edge E holds the value driven after edge E+k*(DIV+1)).
module tb_la_sample_buffer;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0100;
  localparam logic [31:0] R_CTRL = 32'h00, R_STATUS = 32'h04, R_DIV = 32'h08;
  localparam logic [31:0] R_DATA0 = 32'h10, R_DATA3 = 32'h1C;
  localparam logic [127:0] PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic         clk = 1'b0;
  logic         rst;
  logic         stb, cyc, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic [127:0] la_data;

  int checks = 0;
  int errors = 0;

  int edge_n = 0;
  int ramp_base = 0;
  bit ramp_sync = 0;
  int data_mode = 0;   // 0 random, 1 ramp, 2 fixed pattern
  int last_edge;
  logic [127:0] hist [int];
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  la_sample_buffer #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .la_data_in(la_data)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // la_data_in driver: new value 2ns after each edge, logged by edge index.
  initial begin
    la_data = '0;
    forever begin
      @(posedge clk);
      edge_n++;
      #2;
      case (data_mode)
        1:       la_data = 128'(edge_n - ramp_base);
        2:       la_data = PAT;
        default: la_data = {$urandom, $urandom, $urandom, $urandom};
      endcase
      hist[edge_n] = la_data;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] off, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    int ack_edge = -1;
    r = '0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = BASE + off; wdat = d; sel = s;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (ack) begin
        r = rdat;
        ack_edge = edge_n;
        break;
      end
    end
    cyc = 0; stb = 0; we = 0;
    if (ramp_sync && ack_edge >= 0) begin
      ramp_base = ack_edge;
      ramp_sync = 0;
    end
    last_edge = ack_edge;
    check_eq("ack_seen", 128'(ack_edge >= 0), 128'(1));
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_xfer(1'b1, off, d, s, r);
  endtask

  task automatic wb_read(input logic [31:0] off, output logic [31:0] r);
    wb_xfer(1'b0, off, 32'h0, 4'hF, r);
  endtask

  task automatic read_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_read(off, r);
    check_eq(tag, r, exp);
  endtask

  task automatic probe_no_ack(input string tag, input logic [31:0] a, input logic s);
    int acks = 0;
    @(posedge clk); #1;
    cyc = 1; stb = s; we = 0; adr = a;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 0; stb = 0;
    check_eq(tag, acks, 0);
  endtask

  task automatic drain_check(input string tag, input logic [31:0] end_status);
    logic [31:0]  r;
    logic [127:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int w = 0; w < 4; w++) begin
        wb_read(R_DATA0 + 32'(4 * w), r);
        check_eq(tag, r, e[32*w +: 32]);
      end
    end
    read_check({tag, "_status"}, R_STATUS, end_status);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int e, p, d;
    rst = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    #2 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // reset values
    read_check("rst_status", R_STATUS, 32'h1);
    read_check("rst_ctrl", R_CTRL, 32'h0);
    read_check("rst_div", R_DIV, 32'h0);

    // byte lanes, unmapped offset, empty DATA reads, address decode
    wb_write(R_DIV, 32'h0000_1234, 4'hF);
    wb_write(R_DIV, 32'hFFFF_FFAB, 4'b0001);
    read_check("div_bytelane", R_DIV, 32'h0000_12AB);
    wb_write(32'h0C, 32'hDEAD_BEEF, 4'hF);
    read_check("unmapped", 32'h0C, 32'h0);
    read_check("empty_data0", R_DATA0, 32'h0);
    read_check("empty_data3", R_DATA3, 32'h0);
    read_check("empty_pop_ignored", R_STATUS, 32'h1);
    probe_no_ack("nohit_above", BASE + 32'h20, 1'b1);
    probe_no_ack("nohit_below", BASE - 32'h4, 1'b1);
    probe_no_ack("nohit_nostb", BASE + R_STATUS, 1'b0);

    // one-shot captures: ramp DIV=0, ramp DIV=3, fixed pattern, then random
    for (int t = 0; t < 6; t++) begin
      data_mode = (t < 2) ? 1 : (t == 2) ? 2 : 0;
      d = (t == 1) ? 3 : (t < 3) ? 0 : int'($urandom_range(0, 4));
      wb_write(R_DIV, 32'(d), 4'hF);
      ramp_sync = (data_mode == 1);
      wb_write(R_CTRL, 32'h1, 4'hF);
      e = last_edge;
      repeat (DEPTH * (d + 1) + 4) @(posedge clk);
      read_check("oneshot_status", R_STATUS, 32'h0000_0802);
      read_check("oneshot_ctrl", R_CTRL, 32'h0);
      exp_q.delete();
      for (int k = 0; k < DEPTH; k++)
        exp_q.push_back(data_mode == 1 ? 128'(k * (d + 1)) : hist[e + k * (d + 1)]);
      drain_check("oneshot_data", 32'h1);
    end

    // continuous capture with overflow, pop+push while full, then stop
    data_mode = 0;
    wb_write(R_DIV, 32'h0, 4'hF);
    wb_write(R_CTRL, 32'h3, 4'hF);
    e = last_edge;
    repeat (10) @(posedge clk);
    read_check("cont_status", R_STATUS, 32'h0000_080E);
    wb_read(R_DATA3, r);
    p = last_edge;
    check_eq("cont_head_w3", r, hist[e][127:96]);
    read_check("cont_pushpop_full", R_STATUS, 32'h0000_080E);
    wb_write(R_CTRL, 32'h2, 4'hF);
    read_check("cont_stopped", R_STATUS, 32'h0000_080A);
    wb_read(R_DATA3, r);
    check_eq("cont_second_w3", r, hist[e + 1][127:96]);
    read_check("cont_count7", R_STATUS, 32'h0000_0708);
    exp_q.delete();
    for (int k = 2; k < DEPTH; k++) exp_q.push_back(hist[e + k]);
    exp_q.push_back(hist[p - 1]);
    drain_check("cont_data", 32'h9);

    // CLR while sampling, full and overflowed, with a simultaneous ARM write
    wb_write(R_CTRL, 32'h3, 4'hF);
    repeat (12) @(posedge clk);
    wb_write(R_CTRL, 32'h7, 4'hF);
    read_check("clr_status", R_STATUS, 32'h1);
    read_check("clr_ctrl", R_CTRL, 32'h2);
    repeat (5) @(posedge clk);
    read_check("clr_stays_idle", R_STATUS, 32'h1);

    // reset pulsed mid-capture and mid-transfer
    wb_write(R_DIV, 32'h5, 4'hF);
    wb_write(R_CTRL, 32'h3, 4'hF);
    repeat (4) @(posedge clk);
    begin
      int acks = 0;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; adr = BASE + R_STATUS;
      #3 rst = 1;
      #1 check_eq("rst_async_ack", ack, 0);
      check_eq("rst_async_dat", rdat, 0);
      repeat (3) begin
        @(posedge clk); #1;
        if (ack) acks++;
      end
      cyc = 0; stb = 0;
      rst = 0;
      @(posedge clk); #1;
      if (ack) acks++;
      check_eq("rst_no_ack", acks, 0);
    end
    read_check("rst2_status", R_STATUS, 32'h1);
    read_check("rst2_ctrl", R_CTRL, 32'h0);
    read_check("rst2_div", R_DIV, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
